// File: rtl/trig_pkg.sv
// Shared types and helpers for the ADC trigger/capture slice.
package trig_pkg;

    typedef enum logic [1:0] {
        StPretrig,
        StArmed,
        StCapture,
        StDone
    } trig_state_e;

    // Hysteresis threshold: level plus or minus hyst, clamped to [0, max_val].
    function automatic logic [31:0] sat_offset(input logic [31:0] level,
                                               input logic [31:0] hyst,
                                               input logic [31:0] max_val,
                                               input logic        add);
        logic [32:0] sum;
        sum = {1'b0, level} + {1'b0, hyst};
        if (add) begin
            return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
        end
        return (level > hyst) ? (level - hyst) : 32'd0;
    endfunction

endpackage

// File: rtl/edge_detect_hyst.sv
// Edge trigger with hysteresis: the sample must first cross the far threshold
// (setting hf) before a crossing of the level counts as a trigger.
module edge_detect_hyst
    import trig_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned HYST   = 4
) (
    input  logic              adc_clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              track,
    input  logic              armed,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] level,
    input  logic              rising,
    output logic              trig_hit
);

    localparam logic [31:0] MaxVal = 32'((2 ** DATA_W) - 1);

    logic              hf_q;
    logic [DATA_W-1:0] lo_thr;
    logic [DATA_W-1:0] hi_thr;
    logic              set_hf;
    logic              edge_ok;

    // Thresholds, comparisons and the combinational trigger pulse (uses old hf).
    always_comb begin
        lo_thr   = DATA_W'(sat_offset(32'(level), HYST, MaxVal, 1'b0));
        hi_thr   = DATA_W'(sat_offset(32'(level), HYST, MaxVal, 1'b1));
        set_hf   = rising ? (sample_data <= lo_thr) : (sample_data >= hi_thr);
        edge_ok  = rising ? (sample_data >= level) : (sample_data <= level);
        trig_hit = sample_valid && armed && hf_q && edge_ok;
    end

    // Sticky hysteresis flag, cleared only by reset or rearm.
    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            hf_q <= 1'b0;
        end else if (clear) begin
            hf_q <= 1'b0;
        end else if (sample_valid && track && set_hf) begin
            hf_q <= 1'b1;
        end
    end

endmodule

// File: rtl/trigger_capture.sv
// Circular-buffer sample writer with edge/auto trigger and fixed post-trigger capture.
module trigger_capture
    import trig_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned ADR_W        = 12,
    parameter int unsigned PRE_SAMPLES  = 1024,
    parameter int unsigned HYST         = 4,
    parameter int unsigned AUTO_TIMEOUT = 65535
) (
    input  logic              adc_clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_rising,
    input  logic              trig_auto,
    input  logic              rearm,
    output logic              wr_en,
    output logic [ADR_W-1:0]  wr_adr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADR_W-1:0]  trig_adr,
    output logic [ADR_W-1:0]  start_adr,
    output logic              triggered,
    output logic              auto_fired,
    output logic              capture_done
);

    localparam int unsigned DEPTH  = 2 ** ADR_W;
    localparam int unsigned POST   = DEPTH - PRE_SAMPLES;
    localparam int unsigned CntMax = (AUTO_TIMEOUT > DEPTH) ? AUTO_TIMEOUT : DEPTH;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    trig_state_e       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [ADR_W-1:0]  ptr_q, ptr_d;
    logic [ADR_W-1:0]  trig_adr_q, trig_adr_d;
    logic [ADR_W-1:0]  start_adr_q, start_adr_d;
    logic              triggered_q, triggered_d;
    logic              auto_q, auto_d;
    logic              done_q;
    logic              wr_en_q;
    logic [ADR_W-1:0]  wr_adr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [DATA_W-1:0] level_q;
    logic              rising_q;
    logic              auto_mode_q;
    logic              accept;
    logic              timeout_hit;
    logic              trig_hit;

    assign accept      = sample_valid && !rearm && (state_q != StDone);
    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = auto_mode_q && (cnt_inc == CntW'(AUTO_TIMEOUT));

    edge_detect_hyst #(
        .DATA_W (DATA_W),
        .HYST   (HYST)
    ) u_edge (
        .adc_clk      (adc_clk),
        .reset        (reset),
        .clear        (rearm),
        .track        (state_q != StDone),
        .armed        (state_q == StArmed),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .level        (level_q),
        .rising       (rising_q),
        .trig_hit     (trig_hit)
    );

    // Next-state: rearm wins, otherwise each accepted sample advances the counters.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        trig_adr_d  = trig_adr_q;
        start_adr_d = start_adr_q;
        triggered_d = triggered_q;
        auto_d      = auto_q;
        if (rearm) begin
            state_d     = StPretrig;
            cnt_d       = '0;
            ptr_d       = '0;
            triggered_d = 1'b0;
            auto_d      = 1'b0;
        end else if (accept) begin
            ptr_d = ptr_q + 1'b1;
            cnt_d = cnt_inc;
            unique case (state_q)
                StPretrig: begin
                    if (cnt_inc == CntW'(PRE_SAMPLES)) begin
                        state_d = StArmed;
                        cnt_d   = '0;
                    end
                end
                StArmed: begin
                    if (trig_hit || timeout_hit) begin
                        trig_adr_d  = ptr_q;
                        start_adr_d = ptr_q - ADR_W'(PRE_SAMPLES);
                        triggered_d = 1'b1;
                        auto_d      = !trig_hit;
                        cnt_d       = CntW'(1);
                        state_d     = (POST == 1) ? StDone : StCapture;
                    end
                end
                StCapture: begin
                    if (cnt_inc == CntW'(POST)) begin
                        state_d = StDone;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, counters and registered RAM write port.
    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            state_q     <= StPretrig;
            cnt_q       <= '0;
            ptr_q       <= '0;
            trig_adr_q  <= '0;
            start_adr_q <= '0;
            triggered_q <= 1'b0;
            auto_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_adr_q    <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            trig_adr_q  <= trig_adr_d;
            start_adr_q <= start_adr_d;
            triggered_q <= triggered_d;
            auto_q      <= auto_d;
            done_q      <= !rearm && (state_q == StDone);
            wr_en_q     <= accept;
            if (accept) begin
                wr_adr_q  <= ptr_q;
                wr_data_q <= sample_data;
            end
        end
    end

    // Trigger configuration is sampled during reset and rearm only.
    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            level_q     <= trig_level;
            rising_q    <= trig_rising;
            auto_mode_q <= trig_auto;
        end else if (rearm) begin
            level_q     <= trig_level;
            rising_q    <= trig_rising;
            auto_mode_q <= trig_auto;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_adr       = wr_adr_q;
    assign wr_data      = wr_data_q;
    assign trig_adr     = trig_adr_q;
    assign start_adr    = start_adr_q;
    assign triggered    = triggered_q;
    assign auto_fired   = auto_q;
    assign capture_done = done_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Self-checking bench for trigger_capture (ADR_W=4, PRE_SAMPLES=4, HYST=2, AUTO_TIMEOUT=8).
module tb_trigger_capture;

    localparam int PRE   = 4;
    localparam int HY    = 2;
    localparam int AT    = 8;
    localparam int DEPTH = 16;

    logic       adc_clk = 1'b0;
    logic       reset = 1'b0, sample_valid = 1'b0, rearm = 1'b0;
    logic       trig_rising = 1'b1, trig_auto = 1'b0;
    logic [7:0] sample_data = 8'd0, trig_level = 8'd100;
    logic       wr_en, triggered, auto_fired, capture_done;
    logic [7:0] wr_data;
    logic [3:0] wr_adr, trig_adr, start_adr;

    int errors = 0;
    int checks = 0;

    // Reference model: latched config and per-acquisition bookkeeping.
    int c_lvl;
    bit c_rise, c_auto;
    int m_ptr, m_k, m_arm, m_post, m_tadr;
    bit m_hf, m_trig, m_auto, m_done;
    bit e_en, e_cap;
    int e_adr, e_data;

    trigger_capture #(
        .DATA_W       (8),
        .ADR_W        (4),
        .PRE_SAMPLES  (PRE),
        .HYST         (HY),
        .AUTO_TIMEOUT (AT)
    ) dut (
        .adc_clk      (adc_clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .trig_level   (trig_level),
        .trig_rising  (trig_rising),
        .trig_auto    (trig_auto),
        .rearm        (rearm),
        .wr_en        (wr_en),
        .wr_adr       (wr_adr),
        .wr_data      (wr_data),
        .trig_adr     (trig_adr),
        .start_adr    (start_adr),
        .triggered    (triggered),
        .auto_fired   (auto_fired),
        .capture_done (capture_done)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic model_clear();
        c_lvl  = int'(trig_level);
        c_rise = trig_rising;
        c_auto = trig_auto;
        m_ptr  = 0; m_k = 0; m_arm = 0; m_post = 0;
        m_hf   = 0; m_trig = 0; m_auto = 0; m_done = 0;
    endtask

    task automatic do_reset(input int lvl, input bit rise, input bit auto_m);
        @(negedge adc_clk);
        trig_level  = 8'(lvl);
        trig_rising = rise;
        trig_auto   = auto_m;
        reset       = 1'b1;
        model_clear();
        m_tadr = 0; e_en = 0; e_cap = 0;
        @(negedge adc_clk);
        reset = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, leave outputs ready to sample.
    task automatic drive(input bit v, input int d, input bit r);
        bit edge_ok, tmo;
        int lo, hi;
        @(negedge adc_clk);
        sample_valid = v;
        sample_data  = 8'(d);
        rearm        = r;
        @(posedge adc_clk);
        e_cap = !r && m_done;
        e_en  = 0;
        if (r) begin
            model_clear();
        end else if (v && !m_done) begin
            e_en = 1; e_adr = m_ptr; e_data = d;
            if (m_k >= PRE && !m_trig) begin
                m_arm++;
                edge_ok = m_hf && (c_rise ? (d >= c_lvl) : (d <= c_lvl));
                tmo     = c_auto && (m_arm == AT);
                if (edge_ok || tmo) begin
                    m_trig = 1; m_auto = !edge_ok; m_tadr = m_ptr;
                end
            end
            if (m_trig) begin
                m_post++;
                if (m_post == DEPTH - PRE) m_done = 1;
            end
            lo = (c_lvl - HY < 0) ? 0 : c_lvl - HY;
            hi = (c_lvl + HY > 255) ? 255 : c_lvl + HY;
            if (c_rise ? (d <= lo) : (d >= hi)) m_hf = 1;
            m_k++;
            m_ptr = (m_ptr + 1) % DEPTH;
        end
        #1;
        sample_valid = 1'b0;
        rearm        = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(100, 1, 0);
        checks++;
        if ({wr_en, wr_adr, wr_data, trig_adr, start_adr, triggered, auto_fired, capture_done}
            !== 28'd0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b adr=%0d data=%0d tadr=%0d sadr=%0d trg=%b af=%b cd=%b want all 0",
                     wr_en, wr_adr, wr_data, trig_adr, start_adr, triggered, auto_fired,
                     capture_done);
        end
    endtask

    task automatic test_basic();
        do_reset(100, 1, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 50, 0);
            checks++;
            if (wr_en !== 1'b1 || wr_adr !== 4'(i) || wr_data !== 8'd50 || triggered !== 1'b0) begin
                errors++;
                $display("FAIL basic_pre_write%0d: got en=%b adr=%0d data=%0d trg=%b want 1 %0d 50 0",
                         i, wr_en, wr_adr, wr_data, triggered, i);
            end
        end
        drive(1, 120, 0);
        checks++;
        if (triggered !== 1'b1 || trig_adr !== 4'd5 || start_adr !== 4'd1 || wr_adr !== 4'd5
            || auto_fired !== 1'b0) begin
            errors++;
            $display("FAIL basic_trigger: got trg=%b tadr=%0d sadr=%0d wadr=%0d af=%b want 1 5 1 5 0",
                     triggered, trig_adr, start_adr, wr_adr, auto_fired);
        end
        for (int i = 0; i < 11; i++) drive(1, int'($urandom_range(0, 255)), 0);
        checks++;
        if (wr_en !== 1'b1 || wr_adr !== 4'd0 || capture_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_last_write: got en=%b adr=%0d cd=%b want 1 0 0",
                     wr_en, wr_adr, capture_done);
        end
        drive(0, 0, 0);
        checks++;
        if (capture_done !== 1'b1 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got cd=%b en=%b want 1 0", capture_done, wr_en);
        end
        drive(1, 33, 0);
        checks++;
        if (wr_en !== 1'b0 || capture_done !== 1'b1) begin
            errors++;
            $display("FAIL basic_frozen: got en=%b cd=%b want 0 1", wr_en, capture_done);
        end
    endtask

    task automatic test_hysteresis();
        do_reset(100, 1, 0);
        for (int i = 0; i < 4; i++) drive(1, 99, 0);
        drive(1, 99, 0);
        drive(1, 101, 0);
        checks++;
        if (triggered !== 1'b0) begin
            errors++;
            $display("FAIL hyst_no_arm: got trg=%b want 0", triggered);
        end
        drive(1, 97, 0);
        checks++;
        if (triggered !== 1'b0) begin
            errors++;
            $display("FAIL hyst_set_only: got trg=%b want 0", triggered);
        end
        drive(1, 101, 0);
        checks++;
        if (triggered !== 1'b1 || trig_adr !== 4'd7 || start_adr !== 4'd3) begin
            errors++;
            $display("FAIL hyst_trigger: got trg=%b tadr=%0d sadr=%0d want 1 7 3",
                     triggered, trig_adr, start_adr);
        end
    endtask

    task automatic test_falling();
        do_reset(100, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 50, 0);
        drive(1, 103, 0);
        drive(1, 100, 0);
        checks++;
        if (triggered !== 1'b1 || trig_adr !== 4'd5) begin
            errors++;
            $display("FAIL fall_trigger: got trg=%b tadr=%0d want 1 5", triggered, trig_adr);
        end
        do_reset(254, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 254, 0);
        drive(1, 254, 0);
        drive(1, 255, 0);
        checks++;
        if (triggered !== 1'b0) begin
            errors++;
            $display("FAIL fall_sat_early: got trg=%b want 0", triggered);
        end
        drive(1, 254, 0);
        checks++;
        if (triggered !== 1'b1 || trig_adr !== 4'd6) begin
            errors++;
            $display("FAIL fall_sat_trigger: got trg=%b tadr=%0d want 1 6", triggered, trig_adr);
        end
    endtask

    task automatic test_auto();
        do_reset(100, 1, 1);
        for (int i = 0; i < 4; i++) drive(1, 50, 0);
        for (int i = 0; i < 7; i++) drive(1, 50, 0);
        checks++;
        if (triggered !== 1'b0 || auto_fired !== 1'b0) begin
            errors++;
            $display("FAIL auto_early: got trg=%b af=%b want 0 0", triggered, auto_fired);
        end
        drive(0, 0, 0);
        drive(1, 50, 0);
        checks++;
        if (triggered !== 1'b1 || auto_fired !== 1'b1 || trig_adr !== 4'd11) begin
            errors++;
            $display("FAIL auto_fire: got trg=%b af=%b tadr=%0d want 1 1 11",
                     triggered, auto_fired, trig_adr);
        end
    endtask

    task automatic test_rearm();
        do_reset(100, 1, 0);
        for (int i = 0; i < 4; i++) drive(1, 50, 0);
        drive(1, 120, 0);
        for (int i = 0; i < 3; i++) drive(1, 10, 0);
        drive(1, 77, 1);
        checks++;
        if (wr_en !== 1'b0 || triggered !== 1'b0 || auto_fired !== 1'b0 || capture_done !== 1'b0)
        begin
            errors++;
            $display("FAIL rearm_clear: got en=%b trg=%b af=%b cd=%b want 0 0 0 0",
                     wr_en, triggered, auto_fired, capture_done);
        end
        drive(1, 60, 0);
        checks++;
        if (wr_en !== 1'b1 || wr_adr !== 4'd0 || wr_data !== 8'd60) begin
            errors++;
            $display("FAIL rearm_restart: got en=%b adr=%0d data=%0d want 1 0 60",
                     wr_en, wr_adr, wr_data);
        end
        for (int i = 0; i < 20; i++) drive(1, 60, 0);
        checks++;
        if (capture_done !== 1'b0 || triggered !== 1'b0) begin
            errors++;
            $display("FAIL rearm_no_done: got cd=%b trg=%b want 0 0", capture_done, triggered);
        end
    endtask

    task automatic test_async_config();
        do_reset(100, 1, 0);
        for (int i = 0; i < 5; i++) drive(1, 50, 0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({wr_en, wr_adr, wr_data, triggered, capture_done} !== 15'd0) begin
            errors++;
            $display("FAIL async_reset: got en=%b adr=%0d data=%0d trg=%b cd=%b want all 0",
                     wr_en, wr_adr, wr_data, triggered, capture_done);
        end
        model_clear();
        m_tadr = 0; e_en = 0; e_cap = 0;
        @(negedge adc_clk);
        reset = 1'b0;
        trig_level = 8'd200;
        for (int i = 0; i < 4; i++) drive(1, 50, 0);
        drive(1, 120, 0);
        checks++;
        if (triggered !== 1'b1 || trig_adr !== 4'd4) begin
            errors++;
            $display("FAIL config_latched: got trg=%b tadr=%0d want 1 4", triggered, trig_adr);
        end
        trig_level = 8'd100;
    endtask

    task automatic test_random();
        int d;
        do_reset(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) trig_level = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) trig_rising = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) trig_auto = 1'($urandom_range(0, 1));
            d = int'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) begin
                d = c_lvl + int'($urandom_range(0, 16)) - 8;
                d = (d < 0) ? 0 : ((d > 255) ? 255 : d);
            end
            drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 59) == 0);
            checks++;
            if (wr_en !== e_en || (e_en && (wr_adr !== 4'(e_adr) || wr_data !== 8'(e_data)))) begin
                errors++;
                $display("FAIL rnd_write@%0d: got en=%b adr=%0d data=%0d want %b %0d %0d",
                         i, wr_en, wr_adr, wr_data, e_en, e_adr, e_data);
            end
            checks++;
            if (triggered !== m_trig || auto_fired !== m_auto || capture_done !== e_cap) begin
                errors++;
                $display("FAIL rnd_flags@%0d: got trg=%b af=%b cd=%b want %b %b %b",
                         i, triggered, auto_fired, capture_done, m_trig, m_auto, e_cap);
            end
            if (m_trig) begin
                checks++;
                if (trig_adr !== 4'(m_tadr) || start_adr !== 4'((m_tadr - PRE) & 15)) begin
                    errors++;
                    $display("FAIL rnd_adr@%0d: got tadr=%0d sadr=%0d want %0d %0d",
                             i, trig_adr, start_adr, m_tadr, (m_tadr - PRE) & 15);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hysteresis();
        test_falling();
        test_auto();
        test_rearm();
        test_async_config();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
